// File: rtl/proc_mem_lat.sv
// proc_mem_lat: word-addressed SRAM with an instruction read port and a data read/write port, each with latency and in-order response buffering
module proc_mem_lat_port #(
  parameter int LATENCY   = 1,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  input  logic        resp_rdy,
  input  logic [31:0] enq_data,
  output logic        req_rdy,
  output logic        resp_val,
  output logic [31:0] resp_data,
  output logic        acc
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = $clog2(MAX_OUTST + 1);
  logic [31:0]   buf_data [MAX_OUTST];
  logic [1:0]    buf_cnt  [MAX_OUTST];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] outst;
  logic          deq;
  // handshakes; the head entry is presentable once its latency countdown has expired
  always_comb begin
    req_rdy   = !rst && outst < CW'(MAX_OUTST);
    resp_val  = !rst && outst != '0 && buf_cnt[rp] == 2'd0;
    resp_data = resp_val ? buf_data[rp] : 32'd0;
    acc       = req_val && req_rdy;
    deq       = resp_val && resp_rdy;
  end
  // in-order buffer: entries enter with LATENCY-1 cycles still to wait and count down in place
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      outst <= '0;
      for (int i = 0; i < MAX_OUTST; i++) buf_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTST; i++)
        if (buf_cnt[i] != 2'd0) buf_cnt[i] <= buf_cnt[i] - 2'd1;
      if (acc) begin
        buf_data[wp] <= enq_data;
        buf_cnt[wp]  <= 2'(LATENCY - 1);
        wp           <= wp == PW'(MAX_OUTST - 1) ? '0 : wp + PW'(1);
      end
      if (deq) rp <= rp == PW'(MAX_OUTST - 1) ? '0 : rp + PW'(1);
      outst <= outst + CW'(acc) - CW'(deq);
    end
  end
endmodule

module proc_mem_lat #(
  parameter int NWORDS    = 64,
  parameter int LATENCY   = 1,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  input  logic        imemresp_rdy,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  input  logic [3:0]  dmemreq_wstrb,
  output logic        dmemresp_val,
  input  logic        dmemresp_rdy,
  output logic [31:0] dmemresp_rdata
);
  localparam int AW = $clog2(NWORDS);
  logic [31:0]   mem [NWORDS];
  logic [AW-1:0] iidx, didx;
  logic [31:0]   i_enq, d_enq;
  logic          i_acc, d_acc;
  logic          unused_bits;
  // reads capture the pre-write word so a same-edge dmem write is never visible
  always_comb begin
    iidx        = imemreq_addr[AW+1:2];
    didx        = dmemreq_addr[AW+1:2];
    i_enq       = mem[iidx];
    d_enq       = dmemreq_type ? 32'd0 : mem[didx];
    unused_bits = ^{imemreq_addr[31:AW+2], imemreq_addr[1:0], dmemreq_addr[31:AW+2], dmemreq_addr[1:0]};
  end
  // storage: cleared on reset, byte-masked writes on accepted dmem writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
    end else if (d_acc && dmemreq_type) begin
      for (int b = 0; b < 4; b++)
        if (dmemreq_wstrb[b]) mem[didx][8*b +: 8] <= dmemreq_wdata[8*b +: 8];
    end
  end
  proc_mem_lat_port #(.LATENCY(LATENCY), .MAX_OUTST(MAX_OUTST)) u_iport (
    .clk       (clk),
    .rst       (rst),
    .req_val   (imemreq_val),
    .resp_rdy  (imemresp_rdy),
    .enq_data  (i_enq),
    .req_rdy   (imemreq_rdy),
    .resp_val  (imemresp_val),
    .resp_data (imemresp_data),
    .acc       (i_acc)
  );
  proc_mem_lat_port #(.LATENCY(LATENCY), .MAX_OUTST(MAX_OUTST)) u_dport (
    .clk       (clk),
    .rst       (rst),
    .req_val   (dmemreq_val),
    .resp_rdy  (dmemresp_rdy),
    .enq_data  (d_enq),
    .req_rdy   (dmemreq_rdy),
    .resp_val  (dmemresp_val),
    .resp_data (dmemresp_rdata),
    .acc       (d_acc)
  );
endmodule

// File: tb/tb_proc_mem_lat.sv
// tb_proc_mem_lat: scoreboard bench for proc_mem_lat with a reference memory model
module tb_proc_mem_lat;
  localparam int NW  = 64;
  localparam int LAT = 2;
  localparam int MO  = 3;
  logic        clk = 1'b0;
  logic        rst;
  logic        imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
  logic [31:0] imemreq_addr, imemresp_data;
  logic        dmemreq_val, dmemreq_rdy, dmemreq_type, dmemresp_val, dmemresp_rdy;
  logic [31:0] dmemreq_addr, dmemreq_wdata, dmemresp_rdata;
  logic [3:0]  dmemreq_wstrb;
  typedef struct { logic [31:0] d; int t; bit bp; } ent_t;
  ent_t        iq[$], dq[$];
  logic [31:0] ref_mem [NW];
  int          checks = 0, errors = 0, cyc = 0;
  bit          bp = 0, ph_i = 0;
  logic [31:0] pd_i = 0;

  proc_mem_lat #(.NWORDS(NW), .LATENCY(LAT), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata), .dmemreq_wstrb(dmemreq_wstrb),
    .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy), .dmemresp_rdata(dmemresp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mid-cycle monitor: predicts accepts at the coming edge and scores handshaking responses
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      check("rst_ctl", {imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val}, 0);
      check("rst_data", imemresp_data | dmemresp_rdata, 0);
      iq.delete();
      dq.delete();
      for (int i = 0; i < NW; i++) ref_mem[i] = 0;
      ph_i = 0;
    end else begin
      if (ph_i) begin
        check("ihold_val", imemresp_val, 1);
        check("ihold_data", imemresp_data, pd_i);
      end
      ph_i = imemresp_val && !imemresp_rdy;
      pd_i = imemresp_data;
      if (!imemresp_val) check("idata_idle", imemresp_data, 0);
      if (!dmemresp_val) check("ddata_idle", dmemresp_rdata, 0);
      if (imemresp_val && imemresp_rdy) begin
        if (iq.size() == 0) check("i_unexpected", 1, 0);
        else begin
          e = iq.pop_front();
          check("idata", imemresp_data, e.d);
          if (e.bp) check("ilat_min", cyc - e.t >= LAT, 1);
          else check("ilat", cyc - e.t, LAT);
        end
      end
      if (dmemresp_val && dmemresp_rdy) begin
        if (dq.size() == 0) check("d_unexpected", 1, 0);
        else begin
          e = dq.pop_front();
          check("ddata", dmemresp_rdata, e.d);
          if (e.bp) check("dlat_min", cyc - e.t >= LAT, 1);
          else check("dlat", cyc - e.t, LAT);
        end
      end
      if (imemreq_val && imemreq_rdy) iq.push_back('{ref_mem[imemreq_addr[7:2]], cyc, bp});
      if (dmemreq_val && dmemreq_rdy) begin
        dq.push_back('{dmemreq_type ? 32'd0 : ref_mem[dmemreq_addr[7:2]], cyc, bp});
        if (dmemreq_type)
          for (int b = 0; b < 4; b++)
            if (dmemreq_wstrb[b]) ref_mem[dmemreq_addr[7:2]][8*b +: 8] = dmemreq_wdata[8*b +: 8];
      end
    end
  end

  task automatic issue(input bit ion, input logic [31:0] ia, input bit don, input bit dt,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws);
    bit ip = ion, dp = don, ia_ok, da_ok;
    imemreq_val = ion; imemreq_addr = ia;
    dmemreq_val = don; dmemreq_type = dt; dmemreq_addr = da; dmemreq_wdata = wd; dmemreq_wstrb = ws;
    for (int n = 0; n < 50 && (ip || dp); n++) begin
      @(negedge clk);
      ia_ok = ip && imemreq_rdy;
      da_ok = dp && dmemreq_rdy;
      @(posedge clk);
      #1;
      if (ia_ok) begin ip = 0; imemreq_val = 0; end
      if (da_ok) begin dp = 0; dmemreq_val = 0; end
    end
    if (ip || dp) begin
      check("req_timeout", {ip, dp}, 0);
      imemreq_val = 0;
      dmemreq_val = 0;
    end
  endtask

  task automatic drain();
    imemresp_rdy = 1;
    dmemresp_rdy = 1;
    for (int n = 0; n < 200 && (iq.size() + dq.size()) != 0; n++) @(negedge clk);
    check("drain", iq.size() + dq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; imemreq_val = 0; imemreq_addr = 0; imemresp_rdy = 1;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0; dmemreq_wstrb = 0; dmemresp_rdy = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rdy_after_rst", {imemreq_rdy, dmemreq_rdy}, 2'b11);
    issue(0, 0, 1, 1, 32'h8, 32'hDEADBEEF, 4'hF);
    issue(1, 32'h8, 0, 0, 0, 0, 0);
    drain();
    issue(0, 0, 1, 1, 32'h4, 32'h11223344, 4'hF);
    issue(0, 0, 1, 1, 32'h4, 32'hAABBCCDD, 4'h5);
    issue(0, 0, 1, 0, 32'h4, 0, 0);
    issue(0, 0, 1, 1, 32'h4, 32'hFFFFFFFF, 4'h0);
    issue(1, 32'h4, 0, 0, 0, 0, 0);
    drain();
    issue(1, 32'hC, 1, 1, 32'hC, 32'h55, 4'hF);
    issue(1, 32'hC, 0, 0, 0, 0, 0);
    drain();
    issue(0, 0, 1, 1, 32'h100, 32'h77, 4'hF);
    issue(1, 32'h0, 1, 0, 32'h0, 0, 0);
    drain();
    for (int k = 0; k < 24; k++)
      issue(1, $urandom_range(0, 255), 1, 1'($urandom), $urandom_range(0, 255), $urandom, 4'($urandom));
    drain();
    bp = 1;
    imemresp_rdy = 0;
    issue(1, 32'h0, 0, 0, 0, 0, 0);
    issue(1, 32'h4, 0, 0, 0, 0, 0);
    issue(1, 32'h8, 0, 0, 0, 0, 0);
    imemreq_val = 1; imemreq_addr = 32'hC;
    repeat (4) @(negedge clk);
    check("bp_rdy", imemreq_rdy, 0);
    check("bp_outst", iq.size(), 3);
    imemresp_rdy = 1;
    issue(1, 32'hC, 0, 0, 0, 0, 0);
    drain();
    imemresp_rdy = 0;
    dmemresp_rdy = 0;
    issue(1, 32'h8, 1, 0, 32'h8, 0, 0);
    issue(1, 32'h4, 1, 0, 32'h4, 0, 0);
    #1 rst = 1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rdy_rise", {imemreq_rdy, dmemreq_rdy, imemresp_val, dmemresp_val}, 4'b1100);
    bp = 0;
    imemresp_rdy = 1;
    dmemresp_rdy = 1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    for (int w = 0; w < NW; w++) issue(1, w * 4, 1, 0, w * 4 + NW * 4, 0, 0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
